// File: rtl/seg_display_scheduler.sv
// Shares the four-digit 7-segment display between the UART Tx/Rx byte paths and an error flag:
// arbitrates requests, holds each accepted message for a minimum time and scans the digit anodes.
module seg_display_scheduler #(
    parameter int unsigned SCAN_DIV    = 1250,
    parameter int unsigned BLANK_CYC   = 2,
    parameter int unsigned HOLD_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ack,
    input  logic       err_req,
    output logic       an3,
    output logic       an2,
    output logic       an1,
    output logic       an0,
    output logic [4:0] char,
    output logic [1:0] src_id,
    output logic       busy
);
    localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned CH_W   = 5;

    localparam logic [CH_W-1:0] CH_BLANK = 5'h10;
    localparam logic [CH_W-1:0] CH_T     = 5'h11;
    localparam logic [CH_W-1:0] CH_R     = 5'h12;
    localparam logic [CH_W-1:0] CH_DASH  = 5'h13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_LINGER = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_scan_cnt;
    logic [1:0]           r_dig;
    logic [3:0]           r_an;
    logic [CH_W-1:0]      r_char;
    logic [3:0][CH_W-1:0] r_msg;
    logic [HOLD_W-1:0]    r_hold;
    logic                 r_rr_tx;
    logic                 r_tx_ack;
    logic                 r_rx_ack;
    logic                 r_busy;
    logic [1:0]           r_src;

    logic                 w_cnt_wrap;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [1:0]           w_dig_nxt;
    logic                 w_pick_tx;
    logic [7:0]           w_sel_data;
    logic [CH_W-1:0]      w_sel_lead;

    // Next scan position and the arbitration winner for this cycle
    always_comb begin
        w_cnt_wrap = (r_scan_cnt == CNT_W'(SCAN_DIV - 1));
        w_cnt_nxt  = w_cnt_wrap ? '0 : r_scan_cnt + 1'b1;
        w_dig_nxt  = w_cnt_wrap ? r_dig + 2'd1 : r_dig;
        w_pick_tx  = tx_valid && (!rx_valid || r_rr_tx);
        w_sel_data = w_pick_tx ? tx_data : rx_data;
        w_sel_lead = w_pick_tx ? CH_T : CH_R;
    end

    // Anodes and char are registered from the next scan position so they line up with the counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_dig      <= 2'd0;
            r_an       <= 4'hF;
            r_char     <= CH_BLANK;
        end else begin
            r_scan_cnt <= w_cnt_nxt;
            r_dig      <= w_dig_nxt;
            r_an       <= (w_cnt_nxt < CNT_W'(BLANK_CYC)) ? 4'hF : ~(4'b0001 << w_dig_nxt);
            if (w_cnt_wrap) begin
                r_char <= r_msg[w_dig_nxt];
            end
        end
    end

    // Arbitration / hold FSM; err_req overrides everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_msg    <= {4{CH_BLANK}};
            r_hold   <= '0;
            r_rr_tx  <= 1'b1;
            r_tx_ack <= 1'b0;
            r_rx_ack <= 1'b0;
            r_busy   <= 1'b0;
            r_src    <= 2'd0;
        end else begin
            r_tx_ack <= 1'b0;
            r_rx_ack <= 1'b0;
            if (err_req) begin
                r_state <= ST_ERR;
                r_msg   <= {4{CH_DASH}};
                r_src   <= 2'd3;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    ST_ERR: begin
                        r_state <= ST_IDLE;
                        r_msg   <= {4{CH_BLANK}};
                        r_src   <= 2'd0;
                        r_busy  <= 1'b0;
                    end
                    ST_SHOW: begin
                        if (r_hold == '0) begin
                            r_state <= ST_LINGER;
                            r_busy  <= 1'b0;
                        end else begin
                            r_hold <= r_hold - 1'b1;
                        end
                    end
                    ST_IDLE, ST_LINGER: begin
                        if (tx_valid || rx_valid) begin
                            r_state  <= ST_SHOW;
                            r_busy   <= 1'b1;
                            r_hold   <= HOLD_W'(HOLD_CYCLES - 1);
                            r_msg    <= {w_sel_lead, CH_BLANK,
                                         CH_W'(w_sel_data[7:4]), CH_W'(w_sel_data[3:0])};
                            r_src    <= w_pick_tx ? 2'd1 : 2'd2;
                            r_tx_ack <= w_pick_tx;
                            r_rx_ack <= !w_pick_tx;
                            if (tx_valid && rx_valid) begin
                                r_rr_tx <= !r_rr_tx;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign {an3, an2, an1, an0} = r_an;
    assign char                 = r_char;
    assign src_id               = r_src;
    assign busy                 = r_busy;
    assign tx_ack               = r_tx_ack;
    assign rx_ack               = r_rx_ack;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Randomized bench for seg_display_scheduler against a cycle-indexed behavioural model:
// scan outputs derived arithmetically from the cycle count, arbitration from the message rules.
module tb_seg_display_scheduler;
    localparam int SCAN_DIV    = 8;
    localparam int BLANK_CYC   = 2;
    localparam int HOLD_CYCLES = 20;

    localparam int M_IDLE   = 0;
    localparam int M_SHOW   = 1;
    localparam int M_LINGER = 2;
    localparam int M_ERR    = 3;

    localparam int C_BLANK = 16;
    localparam int C_T     = 17;
    localparam int C_R     = 18;
    localparam int C_DASH  = 19;

    logic       clk;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ack;
    logic       err_req;
    logic       an3, an2, an1, an0;
    logic [4:0] char;
    logic [1:0] src_id;
    logic       busy;

    seg_display_scheduler #(
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ack  (tx_ack),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ack  (rx_ack),
        .err_req (err_req),
        .an3     (an3),
        .an2     (an2),
        .an1     (an1),
        .an0     (an0),
        .char    (char),
        .src_id  (src_id),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: cycle index since reset release, display content, expected pulses
    int m_k;
    int m_mode;
    int m_msg [4];
    int m_char;
    int m_src;
    int m_show_until;
    bit m_txack;
    bit m_rxack;
    bit m_rr_tx;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", tag, got, exp, m_k, $time);
        end
    endtask

    task automatic model_reset();
        m_k          = 0;
        m_mode       = M_IDLE;
        foreach (m_msg[i]) m_msg[i] = C_BLANK;
        m_char       = C_BLANK;
        m_src        = 0;
        m_show_until = 0;
        m_txack      = 1'b0;
        m_rxack      = 1'b0;
        m_rr_tx      = 1'b1;
    endtask

    // Advance the model from cycle m_k to m_k+1 using the inputs presented now
    task automatic model_advance();
        bit take_tx;
        logic [7:0] d;
        m_txack = 1'b0;
        m_rxack = 1'b0;
        if ((m_k + 1) % SCAN_DIV == 0) m_char = m_msg[((m_k + 1) / SCAN_DIV) % 4];
        if (err_req) begin
            m_mode = M_ERR;
            foreach (m_msg[i]) m_msg[i] = C_DASH;
            m_src = 3;
        end else if (m_mode == M_ERR) begin
            m_mode = M_IDLE;
            foreach (m_msg[i]) m_msg[i] = C_BLANK;
            m_src = 0;
        end else if (m_mode == M_SHOW) begin
            if (m_k >= m_show_until) m_mode = M_LINGER;
        end else if (tx_valid || rx_valid) begin
            take_tx = tx_valid && (!rx_valid || m_rr_tx);
            if (tx_valid && rx_valid) m_rr_tx = !m_rr_tx;
            d        = take_tx ? tx_data : rx_data;
            m_msg[3] = take_tx ? C_T : C_R;
            m_msg[2] = C_BLANK;
            m_msg[1] = int'(d[7:4]);
            m_msg[0] = int'(d[3:0]);
            m_src    = take_tx ? 1 : 2;
            m_txack  = take_tx;
            m_rxack  = !take_tx;
            m_mode   = M_SHOW;
            m_show_until = m_k + HOLD_CYCLES;
        end
        m_k++;
    endtask

    task automatic check_outputs();
        int pos;
        int dig;
        logic [3:0] exp_an;
        pos    = m_k % SCAN_DIV;
        dig    = (m_k / SCAN_DIV) % 4;
        exp_an = 4'hF;
        if (pos >= BLANK_CYC) exp_an[dig] = 1'b0;
        check_eq("anodes", {28'd0, an3, an2, an1, an0}, {28'd0, exp_an});
        check_eq("char",   {27'd0, char}, m_char);
        check_eq("src_id", {30'd0, src_id}, m_src);
        check_eq("busy",   {31'd0, busy}, {31'd0, (m_mode == M_SHOW || m_mode == M_ERR)});
        check_eq("acks",   {30'd0, tx_ack, rx_ack}, {30'd0, m_txack, m_rxack});
    endtask

    // One clock: model advance, sample at negedge, requesters drop valid once acked
    task automatic cycle_step();
        model_advance();
        @(negedge clk);
        check_outputs();
        if (tx_ack) tx_valid = 1'b0;
        if (rx_ack) rx_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle_step();
    endtask

    initial begin
        int err_left;
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        err_req  = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_outputs();
        end
        reset = 1'b1;
        check_outputs();

        run(64);

        tx_data = 8'hA5; tx_valid = 1'b1;
        run(40);

        tx_data = 8'h5A; tx_valid = 1'b1;
        run(8);
        err_req = 1'b1;
        run(30);
        err_req = 1'b0;
        run(6);

        tx_data = 8'h3C; tx_valid = 1'b1;
        rx_data = 8'h7E; rx_valid = 1'b1;
        run(60);

        err_req = 1'b1;
        run(2);
        err_req = 1'b0;
        run(3);
        err_req = 1'b1; tx_data = 8'h99; tx_valid = 1'b1;
        run(10);
        err_req = 1'b0;
        run(30);

        // Reset in the middle of a SHOW and in the middle of a digit slot
        tx_data = 8'h12; tx_valid = 1'b1;
        run(5);
        rx_data = 8'h34; rx_valid = 1'b1;
        for (int i = 0; i < SCAN_DIV && (m_k % SCAN_DIV) != 4; i++) cycle_step();
        #2 reset = 1'b0;
        model_reset();
        #1 check_outputs();
        repeat (2) begin
            @(negedge clk);
            check_outputs();
        end
        reset = 1'b1;
        check_outputs();
        run(30);

        err_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!tx_valid && $urandom_range(0, 7) == 0) begin
                tx_data  = 8'($urandom_range(0, 255));
                tx_valid = 1'b1;
            end
            if (!rx_valid && $urandom_range(0, 7) == 0) begin
                rx_data  = 8'($urandom_range(0, 255));
                rx_valid = 1'b1;
            end
            if (err_left > 0) begin
                err_left--;
                if (err_left == 0) err_req = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                err_req  = 1'b1;
                err_left = int'($urandom_range(1, 12));
            end
            cycle_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Shares the four-digit 7-segment display between two byte producers (UART Tx path, UART Rx path) and a level error flag.
- Arbitrates the requests, holds each accepted message for a minimum time and time-multiplexes the digit anodes.
- Drives a 5-bit character code into the downstream segment decoder.
- Sits between the UART datapath and the display decoder, replacing the free-running digit counter.

Parameters:
- SCAN_DIV, 1250: clock cycles per digit slot; legal range is 4 or more.
- BLANK_CYC, 2: cycles at the start of each slot with all anodes off (anti-ghosting); must be less than SCAN_DIV.
- HOLD_CYCLES, 5000000: minimum number of cycles an accepted Tx/Rx message stays displayed; must be 1 or more.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tx_valid  in  1  Tx byte request; held high until tx_ack
- tx_data  in  8  Tx byte
- tx_ack  out  1  one-cycle accept pulse for Tx
- rx_valid  in  1  Rx byte request; held high until rx_ack
- rx_data  in  8  Rx byte
- rx_ack  out  1  one-cycle accept pulse for Rx
- err_req  in  1  error level; display "----" while high
- an3, an2, an1, an0  out  1 each  digit anodes, active-low
- char  out  5  character code for the active digit
- src_id  out  2  current content: 0 = none, 1 = Tx, 2 = Rx, 3 = error
- busy  out  1  high in SHOW or ERR

Behaviour:
- Character codes: 0x00–0x0F hex digit; 0x10 blank; 0x11 't'; 0x12 'r'; 0x13 '-'.
- Message layout (digit3..digit0):
  - Tx: 't', blank, hi nibble, lo nibble.
  - Rx: 'r', blank, hi nibble, lo nibble.
  - Error: '-' on all four digits.
  - IDLE: all blank.
- Reset (reset = 0, asynchronous):
  - State IDLE; all anodes 1; char 0x10.
  - tx_ack = rx_ack = 0; src_id 0; busy 0.
  - Scan counter 0, digit index 0, round-robin pointer favours Tx, hold timer 0.
  - Message registers cleared to blank.
  - Reset asserted mid-message drops the message; an un-acked request is not acked and must be re-presented by the requester.
- Scan:
  - Counter runs 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index increments 0→1→2→3→0.
  - While the counter is below BLANK_CYC, all anodes are 1.
  - Otherwise, only the anode of the current index is 0.
  - char is registered and updated when the counter is 0, from the message registers for the new index.
  - A message change takes effect on char at the next slot start; no mid-slot change.
  - The scan runs continuously in all states.
- FSM states: IDLE, SHOW, LINGER, ERR.
- err_req = 1 in any state: go to ERR next cycle.
  - Messages are overwritten to "----"; src_id 3.
  - An in-progress hold is abandoned; no acks are issued while in ERR.
- ERR with err_req = 0: go to IDLE and blank the message; src_id 0.
- IDLE or LINGER with err_req = 0 and a request pending: accept and go to SHOW.
  - Only tx_valid: accept Tx.
  - Only rx_valid: accept Rx.
  - Both: accept the side the round-robin pointer favours; the pointer then toggles to the other side.
  - Accept cycle N: ack pulse, message registers, src_id and hold timer all update at the N+1 edge (ack high for exactly cycle N+1).
  - Requesters drop valid after seeing ack. A valid still high in the cycle after ack is a new request and is not re-accepted until LINGER.
- SHOW:
  - Hold timer is loaded with HOLD_CYCLES-1 at accept and decrements each cycle.
  - At 0, go to LINGER; SHOW lasts exactly HOLD_CYCLES cycles.
  - Requests arriving during SHOW wait, unacked.
- LINGER: the last message stays displayed, src_id is unchanged and busy is 0. A pending request is accepted in the first LINGER cycle.
- Simultaneous err_req and an accept condition: err_req wins, no ack.
- Counters wrap silently; there is no overflow status.

Test Plan:
- Bench parameters: SCAN_DIV = 8, BLANK_CYC = 2, HOLD_CYCLES = 20.
- Reset then idle 64 cycles → anodes follow 1111 (cycles 0–1), 1110 (cycles 2–7), then the pattern for an1, an2, an3 in turn. char 0x10 throughout; busy 0.
- tx_valid with tx_data = 0xA5 → tx_ack one cycle later. From the next slot starts, char per digit is 0x05, 0x0A, 0x10, 0x11. src_id 1; busy high for exactly 20 cycles, then LINGER with the same display.
- tx_valid and rx_valid both high from IDLE (Tx 0x3C, Rx 0x7E) → Tx acked first. Rx waits 20 cycles and is acked in the first LINGER cycle; then 'r', blank, 7, E is shown with src_id 2.
- err_req pulsed for 30 cycles mid-SHOW of a Tx message → ERR next cycle, all digits 0x13, src_id 3, no acks. On release → IDLE, all blank, src_id 0.
- err_req and tx_valid rising in the same cycle from IDLE → no tx_ack while err_req is high. tx_ack comes the cycle after return to IDLE.
- reset asserted mid-SHOW and mid-slot → anodes immediately 1111, char 0x10, busy 0. A pending rx_valid is not acked until after reset is released.
